// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I decode-stage controller: opcodes, immediate
// formats, write-back selects, FSM states and the control word layout.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic       reg_wen;
        logic       mem_read;
        logic       mem_rw;
        logic       a_sel;
        logic       b_sel;
        logic       branch;
        logic       jump;
        logic [1:0] wb_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decoder: control word, immediate format, register-use
// flags and halt request for the instruction in IF/ID.
module id_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [1:0] i_funct3_lo,
    output ctrl_t      o_ctrl,
    output logic [2:0] o_imm_sel,
    output logic       o_funct7,
    output logic       o_use_rs1,
    output logic       o_use_rs2,
    output logic       o_halt_req
);

    always_comb begin
        o_ctrl     = CTRL_NOP;
        o_imm_sel  = IMM_I;
        o_funct7   = 1'b0;
        o_use_rs1  = 1'b0;
        o_use_rs2  = 1'b0;
        o_halt_req = 1'b0;
        case (i_opcode)
            OP_R: begin
                o_ctrl.reg_wen = 1'b1;
                o_ctrl.wb_sel  = WB_ALU;
                o_use_rs1      = 1'b1;
                o_use_rs2      = 1'b1;
            end
            OP_I_ALU: begin
                o_ctrl.reg_wen = 1'b1;
                o_ctrl.b_sel   = 1'b1;
                o_ctrl.wb_sel  = WB_ALU;
                o_use_rs1      = 1'b1;
                // Shift-immediates carry funct7 in imm[11:5]
                o_funct7       = (i_funct3_lo == 2'b01);
            end
            OP_LOAD: begin
                o_ctrl.reg_wen  = 1'b1;
                o_ctrl.mem_read = 1'b1;
                o_ctrl.b_sel    = 1'b1;
                o_ctrl.wb_sel   = WB_MEM;
                o_use_rs1       = 1'b1;
            end
            OP_STORE: begin
                o_imm_sel     = IMM_S;
                o_ctrl.mem_rw = 1'b1;
                o_ctrl.b_sel  = 1'b1;
                o_use_rs1     = 1'b1;
                o_use_rs2     = 1'b1;
            end
            OP_BRANCH: begin
                o_imm_sel     = IMM_B;
                o_ctrl.branch = 1'b1;
                o_ctrl.a_sel  = 1'b1;
                o_ctrl.b_sel  = 1'b1;
                o_use_rs1     = 1'b1;
                o_use_rs2     = 1'b1;
            end
            OP_LUI: begin
                o_imm_sel      = IMM_U;
                o_ctrl.reg_wen = 1'b1;
                o_ctrl.wb_sel  = WB_IMM;
            end
            OP_AUIPC: begin
                o_imm_sel      = IMM_U;
                o_ctrl.reg_wen = 1'b1;
                o_ctrl.a_sel   = 1'b1;
                o_ctrl.b_sel   = 1'b1;
                o_ctrl.wb_sel  = WB_ALU;
            end
            OP_JAL: begin
                o_imm_sel      = IMM_J;
                o_ctrl.reg_wen = 1'b1;
                o_ctrl.jump    = 1'b1;
                o_ctrl.a_sel   = 1'b1;
                o_ctrl.b_sel   = 1'b1;
                o_ctrl.wb_sel  = WB_PC4;
            end
            OP_JALR: begin
                o_ctrl.reg_wen = 1'b1;
                o_ctrl.jump    = 1'b1;
                o_ctrl.b_sel   = 1'b1;
                o_ctrl.wb_sel  = WB_PC4;
                o_use_rs1      = 1'b1;
            end
            default: o_halt_req = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ctrl_unit.sv
// Decode-stage controller: drives immediate select, registers the ID/EX control
// word, and sequences load-use stalls, flushes and the HALT state.
module id_ctrl_unit
    import rv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_instr,
    input  logic             i_id_valid,
    input  logic             i_flush,
    input  logic             i_resume,
    output logic [2:0]       o_ImmSel,
    output logic             o_Funct7,
    output logic             o_stall,
    output logic             o_halt,
    output logic             o_ex_valid,
    output logic             o_ex_RegWEn,
    output logic             o_ex_MemRead,
    output logic             o_ex_MemRW,
    output logic             o_ex_ASel,
    output logic             o_ex_BSel,
    output logic             o_ex_Branch,
    output logic             o_ex_Jump,
    output logic [1:0]       o_ex_WBSel,
    output logic [4:0]       o_ex_rd
);

    state_t     r_state;
    ctrl_t      r_ex_ctrl;
    logic       r_ex_valid;
    logic [4:0] r_ex_rd;

    ctrl_t      w_ctrl;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_halt_req;
    logic       w_halt_enter;
    logic       w_load_use;
    logic       w_bubble;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_unused;

    assign w_rs1    = i_instr[19:15];
    assign w_rs2    = i_instr[24:20];
    assign w_unused = ^{i_instr[WIDTH-1:25], i_instr[14]};

    id_decoder u_dec (
        .i_opcode    (i_instr[6:0]),
        .i_funct3_lo (i_instr[13:12]),
        .o_ctrl      (w_ctrl),
        .o_imm_sel   (o_ImmSel),
        .o_funct7    (o_Funct7),
        .o_use_rs1   (w_use_rs1),
        .o_use_rs2   (w_use_rs2),
        .o_halt_req  (w_halt_req)
    );

    // Bubbles zero r_ex_rd, so only a real load can raise the hazard
    assign w_load_use = i_id_valid && r_ex_valid && r_ex_ctrl.mem_read &&
                        (r_ex_rd != 5'd0) &&
                        ((w_use_rs1 && (r_ex_rd == w_rs1)) ||
                         (w_use_rs2 && (r_ex_rd == w_rs2)));

    assign w_halt_enter = (r_state == ST_RUN) && i_id_valid && w_halt_req && !i_flush;
    assign o_stall      = !i_flush && ((r_state == ST_HALT) || w_halt_enter || w_load_use);
    assign w_bubble     = i_flush || (r_state == ST_HALT) || w_halt_enter || w_load_use;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_RUN;
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= CTRL_NOP;
            r_ex_rd    <= 5'd0;
        end else begin
            if (!i_flush) begin
                if (w_halt_enter)
                    r_state <= ST_HALT;
                else if ((r_state == ST_HALT) && i_resume)
                    r_state <= ST_RUN;
            end
            if (w_bubble) begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= CTRL_NOP;
                r_ex_rd    <= 5'd0;
            end else begin
                r_ex_valid <= i_id_valid;
                r_ex_ctrl  <= w_ctrl;
                r_ex_rd    <= i_instr[11:7];
            end
        end
    end

    assign o_halt       = (r_state == ST_HALT);
    assign o_ex_valid   = r_ex_valid;
    assign o_ex_RegWEn  = r_ex_ctrl.reg_wen;
    assign o_ex_MemRead = r_ex_ctrl.mem_read;
    assign o_ex_MemRW   = r_ex_ctrl.mem_rw;
    assign o_ex_ASel    = r_ex_ctrl.a_sel;
    assign o_ex_BSel    = r_ex_ctrl.b_sel;
    assign o_ex_Branch  = r_ex_ctrl.branch;
    assign o_ex_Jump    = r_ex_ctrl.jump;
    assign o_ex_WBSel   = r_ex_ctrl.wb_sel;
    assign o_ex_rd      = r_ex_rd;

endmodule

// File: tb/tb_id_ctrl_unit.sv
// Directed bench for id_ctrl_unit: stalls, flushes, HALT/resume, immediate select.
module tb_id_ctrl_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        id_valid;
    logic        flush;
    logic        resume;
    logic [2:0]  ImmSel;
    logic        Funct7;
    logic        stall;
    logic        halt;
    logic        ex_valid;
    logic        ex_RegWEn;
    logic        ex_MemRead;
    logic        ex_MemRW;
    logic        ex_ASel;
    logic        ex_BSel;
    logic        ex_Branch;
    logic        ex_Jump;
    logic [1:0]  ex_WBSel;
    logic [4:0]  ex_rd;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] LW_X5   = 32'h0000A283;
    localparam logic [31:0] ADD_X6  = 32'h00228333;
    localparam logic [31:0] LW_X0   = 32'h0000A003;
    localparam logic [31:0] ADD_X0  = 32'h00000333;
    localparam logic [31:0] ECALL   = 32'h00000073;
    localparam logic [31:0] SRAI    = 32'h40525193;
    localparam logic [31:0] SW      = 32'h0020A023;
    localparam logic [31:0] BEQ     = 32'h00208063;
    localparam logic [31:0] LUI     = 32'h123450B7;
    localparam logic [31:0] JAL     = 32'h000000EF;
    localparam logic [31:0] ADDI    = 32'h00100093;

    id_ctrl_unit #(.WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_instr      (instr),
        .i_id_valid   (id_valid),
        .i_flush      (flush),
        .i_resume     (resume),
        .o_ImmSel     (ImmSel),
        .o_Funct7     (Funct7),
        .o_stall      (stall),
        .o_halt       (halt),
        .o_ex_valid   (ex_valid),
        .o_ex_RegWEn  (ex_RegWEn),
        .o_ex_MemRead (ex_MemRead),
        .o_ex_MemRW   (ex_MemRW),
        .o_ex_ASel    (ex_ASel),
        .o_ex_BSel    (ex_BSel),
        .o_ex_Branch  (ex_Branch),
        .o_ex_Jump    (ex_Jump),
        .o_ex_WBSel   (ex_WBSel),
        .o_ex_rd      (ex_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr = 32'h0; id_valid = 1'b0; flush = 1'b0; resume = 1'b0;
        #1;
        tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_halt", halt, 0);
        chk("rst_regwen", ex_RegWEn, 0);
        chk("rst_rd", ex_rd, 0);
        chk("rst_stall", stall, 0);
        chk("rst_immsel", ImmSel, 0);

        // Load-use: lw x5 then add x6,x5,x2
        rst = 1'b0; instr = LW_X5; id_valid = 1'b1; #1;
        chk("lw_stall", stall, 0);
        tick();
        chk("lw_ex_valid", ex_valid, 1);
        chk("lw_memread", ex_MemRead, 1);
        chk("lw_rd", ex_rd, 5);
        chk("lw_wbsel", ex_WBSel, 0);
        instr = ADD_X6; #1;
        chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_rd", ex_rd, 0);
        chk("lu_stall_clear", stall, 0);
        tick();
        chk("add_ex_valid", ex_valid, 1);
        chk("add_regwen", ex_RegWEn, 1);
        chk("add_wbsel", ex_WBSel, 1);
        chk("add_rd", ex_rd, 6);
        chk("add_memread", ex_MemRead, 0);

        // No stall on x0 destination
        instr = LW_X0; #1;
        chk("lwx0_stall", stall, 0);
        tick();
        chk("lwx0_memread", ex_MemRead, 1);
        instr = ADD_X0; #1;
        chk("addx0_stall", stall, 0);
        tick();
        chk("addx0_ex_valid", ex_valid, 1);

        // Flush wins over a load-use stall
        instr = LW_X5; tick();
        instr = ADD_X6; flush = 1'b1; #1;
        chk("flush_stall", stall, 0);
        tick();
        chk("flush_ex_valid", ex_valid, 0);
        chk("flush_halt", halt, 0);
        flush = 1'b0; id_valid = 1'b0;

        // Immediate select, combinational
        instr = SRAI; #1;
        chk("srai_immsel", ImmSel, 3'b000);
        chk("srai_funct7", Funct7, 1);
        instr = SW; #1;
        chk("sw_immsel", ImmSel, 3'b001);
        chk("sw_funct7", Funct7, 0);
        instr = BEQ; #1;
        chk("beq_immsel", ImmSel, 3'b010);
        instr = LUI; #1;
        chk("lui_immsel", ImmSel, 3'b011);
        instr = JAL; #1;
        chk("jal_immsel", ImmSel, 3'b100);

        // Registered control words
        id_valid = 1'b1; tick();
        chk("jal_jump", ex_Jump, 1);
        chk("jal_asel", ex_ASel, 1);
        chk("jal_bsel", ex_BSel, 1);
        chk("jal_wbsel", ex_WBSel, 2);
        chk("jal_regwen", ex_RegWEn, 1);
        instr = SW; tick();
        chk("sw_memrw", ex_MemRW, 1);
        chk("sw_regwen", ex_RegWEn, 0);
        instr = BEQ; tick();
        chk("beq_branch", ex_Branch, 1);
        chk("beq_asel", ex_ASel, 1);

        // HALT and resume
        instr = ECALL; #1;
        chk("ecall_stall", stall, 1);
        chk("ecall_halt_now", halt, 0);
        tick();
        chk("ecall_halt", halt, 1);
        chk("ecall_no_ex", ex_valid, 0);
        instr = ADDI;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("halt_stall", stall, 1);
            tick();
            chk("halt_ex_valid", ex_valid, 0);
            chk("halt_held", halt, 1);
        end
        flush = 1'b1; #1;
        chk("halt_flush_stall", stall, 0);
        tick();
        chk("halt_flush_stays", halt, 1);
        flush = 1'b0; resume = 1'b1; #1;
        chk("resume_stall", stall, 1);
        tick();
        chk("resume_halt", halt, 0);
        chk("resume_ex_valid", ex_valid, 0);
        resume = 1'b0; #1;
        chk("post_resume_stall", stall, 0);
        tick();
        chk("addi_ex_valid", ex_valid, 1);
        chk("addi_bsel", ex_BSel, 1);
        chk("addi_rd", ex_rd, 1);

        // Reset while halted
        instr = ECALL; tick();
        chk("halt2", halt, 1);
        rst = 1'b1; id_valid = 1'b0; tick();
        chk("rsthalt_halt", halt, 0);
        chk("rsthalt_ex_valid", ex_valid, 0);
        rst = 1'b0; instr = ADDI; id_valid = 1'b1; #1;
        chk("rsthalt_stall", stall, 0);
        tick();
        chk("rsthalt_addi_valid", ex_valid, 1);
        chk("rsthalt_addi_regwen", ex_RegWEn, 1);
        chk("rsthalt_addi_wbsel", ex_WBSel, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
